fpu_result_fifo: RTL and testbench
==================================

# fpu_result_fifo

Result-capture stage directly downstream of the bfloat16 `fpu`. Each cycle the producer may push one result word (`out_o`), its overflow flag (`overflow_o`) and the one-hot op code that produced it into a first-word-fall-through FIFO. Each accepted word is tagged with an IEEE class (zero, subnormal, inf, NaN). Saturating exception counters are kept for status readout by the consumer.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8: width of each exception counter.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `push_i` in 1: result valid from the fpu.
- `res_i` in 16: bfloat16 result (fpu `out_o`).
- `ovf_i` in 1: fpu `overflow_o` for this result.
- `mode_i` in 4: one-hot op code (0001 add, 0010 sub, 0100 mul, 1000 div); stored as-is, not checked.
- `pop_i` in 1: consumer takes the head entry.
- `clr_i` in 1: synchronous clear of both counters.
- `res_o` out 16: head result.
- `ovf_o` out 1: head overflow flag.
- `mode_o` out 4: head op code.
- `class_o` out 4: head class `{nan, inf, sub, zero}`.
- `empty_o` out 1: no entries.
- `full_o` out 1: DEPTH entries.
- `count_o` out $clog2(DEPTH)+1: occupancy.
- `drop_o` out 1: one-cycle pulse; a push was rejected.
- `ovf_cnt_o` out CNT_W: accepted entries with `ovf_i`=1.
- `nan_cnt_o` out CNT_W: accepted entries classified NaN.

## Operation
- Storage: DEPTH × 25 bits: res 16, ovf 1, mode 4, class 4. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter.
- Class is computed from `res_i` at push time, with exp = `res_i[14:7]` and man = `res_i[6:0]`:
  - zero: exp=0, man=0 (either sign).
  - sub: exp=0, man≠0.
  - inf: exp=FF, man=0.
  - nan: exp=FF, man≠0.
  - Normal values give class 0000.
- Push accept rule: `push_i` && (!full || `pop_i`).
- Pop accept rule: `pop_i` && !empty.
- Full + push + pop: both are accepted. Count is unchanged, both pointers advance.
- Empty + push + pop: the pop is ignored and the push is accepted, so count becomes 1.
- Pop while empty: no effect, no error.
- Push while full without pop: the word is discarded. `drop_o`=1 in the next cycle. Counters do not change.
- Counters:
  - `ovf_cnt_o` increments on each accepted push with `ovf_i`=1.
  - `nan_cnt_o` increments on each accepted push classified NaN.
  - Both saturate at 2^CNT_W−1.
  - `clr_i` forces 0. If `clr_i` and an increment occur in the same cycle, clear wins.
- FWFT outputs: while !empty, `res_o`/`ovf_o`/`mode_o`/`class_o` show the entry at the read pointer. While empty, they are all 0.

## Timing
- Reset (`rst`=0, asynchronous): pointers and count go to 0. `empty_o`=1, `full_o`=0, `drop_o`=0, both counters 0, all head outputs 0. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge. Release is synchronous to `clk`.
- Push-to-output latency: a word accepted at edge N appears on the head outputs after edge N, when the FIFO was empty.
- Pop: the head advances after the accepting edge. The next entry, or zeros if empty, is visible in the same cycle.
- `empty_o`, `full_o`, `count_o` and the counters are registered or derived from registered state. They change only after a clock edge, never combinationally from `push_i`/`pop_i`.
- `drop_o` is a registered pulse, asserted for exactly one cycle per rejected push.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset: hold `rst`=0, then release.
  - Required: `empty_o`=1, `count_o`=0, `res_o`=0000, `class_o`=0000, both counters 0.
  - Assert `rst`=0 with 3 entries held: `empty_o`=1 immediately, without a clock edge.
- Fill and overflow: push 8 words 0x3F80, 0x4000, …, with pop_i=0.
  - Required: `full_o`=1, `count_o`=8.
  - A 9th push of 0x1234 gives one `drop_o` pulse. Popping 8 times returns the original 8 in order, with 0x1234 absent.
- Simultaneous events:
  - At full, push 0xC000 with pop: count stays 8, the old head is removed, and 0xC000 becomes the tail.
  - At empty, push 0x3F80 with pop: count=1, `res_o`=3F80 the next cycle.
- Classification: push 0x7F80, 0x7FC0, 0x0001, 0x8000, 0x3F80.
  - Required `class_o` on pop: 0100, 1000, 0010, 0001, 0000.
  - Required `nan_cnt_o`=1.
- Counter saturation with CNT_W=2: push 5 words with `ovf_i`=1 (e.g. res 0x7F80, mode 0100).
  - Required: `ovf_cnt_o`=3.
  - `clr_i` together with another ovf push gives `ovf_cnt_o`=0.
- Pointer wrap-around: 20 cycles of continuous push+pop of an incrementing pattern (0x0001…0x0014).
  - Required: output sequence equals input sequence delayed by one entry, `count_o` constant at 1, no `drop_o`.

Source files
------------

// File: rtl/fpu_result_fifo.sv
// Generic first-word-fall-through FIFO storage with occupancy counter.
// Latency: a word written at edge N is visible on rd_dat after edge N; read data is zero while empty.
// Backpressure: write accepted when not full or when a read is accepted in the same cycle.
module gen_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_acc,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     rd_vld,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             rd_acc;

    // Status is derived from the registered occupancy only.
    assign rd_vld = (count != '0);
    assign full   = (count == (AW+1)'(DEPTH));

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign rd_acc = rd_rdy && rd_vld;
    assign wr_acc = wr_vld && (!full || rd_rdy);

    // Head data falls through; zeros when nothing is held.
    assign rd_dat = rd_vld ? mem[rptr] : '0;

    // Storage array carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracked separately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Result-capture FIFO behind the bfloat16 fpu: tags each word with its class and counts exceptions.
// Latency: accepted word reaches the head outputs one edge later when empty; drop pulse one cycle after rejection.
// Backpressure: none upstream; pushes into a full FIFO without a pop are discarded and flagged on drop_o.
module fpu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [15:0]              res_i,
    input  logic                     ovf_i,
    input  logic [3:0]               mode_i,
    input  logic                     pop_i,
    input  logic                     clr_i,
    output logic [15:0]              res_o,
    output logic                     ovf_o,
    output logic [3:0]               mode_o,
    output logic [3:0]               class_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o,
    output logic [CNT_W-1:0]         ovf_cnt_o,
    output logic [CNT_W-1:0]         nan_cnt_o
);
    localparam int EW = 25;

    logic [7:0]    res_exp;
    logic [6:0]    res_man;
    logic [3:0]    res_class;
    logic [EW-1:0] wr_dat;
    logic [EW-1:0] rd_dat;
    logic          wr_acc;
    logic          rd_vld;
    logic          full;

    assign res_exp = res_i[14:7];
    assign res_man = res_i[6:0];

    // Class bits {nan, inf, sub, zero}; normal numbers leave all bits clear.
    always_comb begin
        res_class = 4'b0000;
        if (res_exp == 8'h00) begin
            if (res_man == 7'h00) begin
                res_class = 4'b0001;
            end else begin
                res_class = 4'b0010;
            end
        end else if (res_exp == 8'hFF) begin
            if (res_man == 7'h00) begin
                res_class = 4'b0100;
            end else begin
                res_class = 4'b1000;
            end
        end
    end

    assign wr_dat = {res_i, ovf_i, mode_i, res_class};

    gen_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_i),
        .wr_dat (wr_dat),
        .wr_acc (wr_acc),
        .rd_rdy (pop_i),
        .rd_dat (rd_dat),
        .rd_vld (rd_vld),
        .full   (full),
        .count  (count_o)
    );

    assign res_o   = rd_dat[24:9];
    assign ovf_o   = rd_dat[8];
    assign mode_o  = rd_dat[7:4];
    assign class_o = rd_dat[3:0];
    assign empty_o = !rd_vld;
    assign full_o  = full;

    // One-cycle pulse for every push that found no room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_o <= 1'b0;
        end else begin
            drop_o <= push_i && !wr_acc;
        end
    end

    // Saturating exception counters over accepted pushes; clear takes priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_o <= '0;
            nan_cnt_o <= '0;
        end else if (clr_i) begin
            ovf_cnt_o <= '0;
            nan_cnt_o <= '0;
        end else begin
            if (wr_acc && ovf_i && (ovf_cnt_o != '1)) begin
                ovf_cnt_o <= ovf_cnt_o + CNT_W'(1);
            end
            if (wr_acc && res_class[3] && (nan_cnt_o != '1)) begin
                nan_cnt_o <= nan_cnt_o + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fpu_result_fifo.sv
module tb_fpu_result_fifo;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_i = 1'b0;
    logic [15:0] res_i = '0;
    logic        ovf_i = 1'b0;
    logic [3:0]  mode_i = '0;
    logic        pop_i = 1'b0;
    logic        clr_i = 1'b0;

    logic [15:0]   res_o, res2_o;
    logic          ovf_o, ovf2_o;
    logic [3:0]    mode_o, mode2_o, class_o, class2_o;
    logic          empty_o, empty2_o, full_o, full2_o, drop_o, drop2_o;
    logic [CW-1:0] count_o, count2_o;
    logic [7:0]    ovf_cnt_o, nan_cnt_o;
    logic [1:0]    ovf_cnt2_o, nan_cnt2_o;

    always #5 clk = ~clk;

    fpu_result_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .push_i(push_i), .res_i(res_i), .ovf_i(ovf_i),
        .mode_i(mode_i), .pop_i(pop_i), .clr_i(clr_i), .res_o(res_o), .ovf_o(ovf_o),
        .mode_o(mode_o), .class_o(class_o), .empty_o(empty_o), .full_o(full_o),
        .count_o(count_o), .drop_o(drop_o), .ovf_cnt_o(ovf_cnt_o), .nan_cnt_o(nan_cnt_o)
    );

    fpu_result_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .push_i(push_i), .res_i(res_i), .ovf_i(ovf_i),
        .mode_i(mode_i), .pop_i(pop_i), .clr_i(clr_i), .res_o(res2_o), .ovf_o(ovf2_o),
        .mode_o(mode2_o), .class_o(class2_o), .empty_o(empty2_o), .full_o(full2_o),
        .count_o(count2_o), .drop_o(drop2_o), .ovf_cnt_o(ovf_cnt2_o), .nan_cnt_o(nan_cnt2_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of {res, ovf, mode, class} plus plain integer counters.
    logic [24:0] q[$];
    int   m_ovf, m_nan, m_ovf2, m_nan2;
    logic m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_class(input logic [15:0] r);
        int e, m;
        e = int'(r[14:7]);
        m = int'(r[6:0]);
        if (e == 0 && m == 0) return 4'b0001;
        if (e == 0)           return 4'b0010;
        if (e == 255 && m == 0) return 4'b0100;
        if (e == 255)         return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf = 0; m_nan = 0; m_ovf2 = 0; m_nan2 = 0;
        m_drop = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [24:0] h;
        h = (q.size() != 0) ? q[0] : 25'd0;
        chk({tag, ":res"},   32'(res_o),   32'(h[24:9]));
        chk({tag, ":ovf"},   32'(ovf_o),   32'(h[8]));
        chk({tag, ":mode"},  32'(mode_o),  32'(h[7:4]));
        chk({tag, ":class"}, 32'(class_o), 32'(h[3:0]));
        chk({tag, ":empty"}, 32'(empty_o), 32'(q.size() == 0));
        chk({tag, ":full"},  32'(full_o),  32'(q.size() == DEPTH));
        chk({tag, ":count"}, 32'(count_o), 32'(q.size()));
        chk({tag, ":drop"},  32'(drop_o),  32'(m_drop));
        chk({tag, ":ovfc"},  32'(ovf_cnt_o), 32'(m_ovf));
        chk({tag, ":nanc"},  32'(nan_cnt_o), 32'(m_nan));
        chk({tag, ":res2"},  32'({res2_o, ovf2_o, mode2_o, class2_o}), 32'(h));
        chk({tag, ":st2"},   32'({empty2_o, full2_o, count2_o, drop2_o}),
            32'({q.size() == 0, q.size() == DEPTH, CW'(q.size()), m_drop}));
        chk({tag, ":ovfc2"}, 32'(ovf_cnt2_o), 32'(m_ovf2));
        chk({tag, ":nanc2"}, 32'(nan_cnt2_o), 32'(m_nan2));
    endtask

    // One clock cycle: drive, clock, update model, check everything 1 time unit after the edge.
    task automatic cyc(input string tag, input logic p, input logic [15:0] r, input logic o,
                       input logic [3:0] m, input logic pp, input logic c);
        logic pacc, racc;
        push_i = p; res_i = r; ovf_i = o; mode_i = m; pop_i = pp; clr_i = c;
        @(posedge clk);
        racc = pp && (q.size() != 0);
        pacc = p && ((q.size() < DEPTH) || pp);
        if (racc) void'(q.pop_front());
        if (pacc) q.push_back({r, o, m, ref_class(r)});
        m_drop = p && !pacc;
        if (c) begin
            m_ovf = 0; m_nan = 0; m_ovf2 = 0; m_nan2 = 0;
        end else if (pacc) begin
            if (o) begin
                m_ovf  = sat_inc(m_ovf, 255);
                m_ovf2 = sat_inc(m_ovf2, 3);
            end
            if (ref_class(r) == 4'b1000) begin
                m_nan  = sat_inc(m_nan, 255);
                m_nan2 = sat_inc(m_nan2, 3);
            end
        end
        #1;
        check_all(tag);
        push_i = 1'b0; pop_i = 1'b0; clr_i = 1'b0; ovf_i = 1'b0;
    endtask

    // Asynchronous reset assertion mid-cycle, release away from the clock edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, ":async_empty"}, 32'(empty_o), 32'd1);
        chk({tag, ":async_count"}, 32'(count_o), 32'd0);
        model_clear();
        check_all({tag, ":in_rst"});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ":post_rst"});
    endtask

    initial begin
        logic [15:0] r;
        logic [3:0]  md;
        int k, pp_pct, pu_pct;

        model_clear();
        // Reset held low from time zero
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        chk("reset_res",   32'(res_o),   32'h0);
        chk("reset_class", 32'(class_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_release");

        // Asynchronous reset with 3 entries held
        for (int i = 0; i < 3; i++) cyc("pre3", 1'b1, 16'h4000 + 16'(i), 1'b0, 4'b0001, 1'b0, 1'b0);
        chk("three_held", 32'(count_o), 32'd3);
        do_reset("mid_rst");

        // Fill and overflow
        for (int i = 0; i < 8; i++) cyc("fill", 1'b1, 16'h3F80 + 16'(i * 16'h80), 1'b0, 4'b0001, 1'b0, 1'b0);
        chk("fill_full",  32'(full_o),  32'd1);
        chk("fill_count", 32'(count_o), 32'd8);
        cyc("ovfpush", 1'b1, 16'h1234, 1'b0, 4'b0001, 1'b0, 1'b0);
        chk("drop_pulse", 32'(drop_o), 32'd1);
        cyc("idle", 1'b0, 16'h0, 1'b0, 4'b0, 1'b0, 1'b0);
        chk("drop_once", 32'(drop_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("fill_order", 32'(res_o), 32'(16'h3F80 + 16'(i * 16'h80)));
            cyc("drain", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty_o), 32'd1);

        // Full + push + pop
        for (int i = 0; i < 8; i++) cyc("refill", 1'b1, 16'h3F80 + 16'(i * 16'h80), 1'b0, 4'b0010, 1'b0, 1'b0);
        cyc("full_pp", 1'b1, 16'hC000, 1'b0, 4'b0100, 1'b1, 1'b0);
        chk("full_pp_count", 32'(count_o), 32'd8);
        chk("full_pp_head",  32'(res_o),   32'h4000);
        chk("full_pp_drop",  32'(drop_o),  32'd0);
        for (int i = 0; i < 7; i++) cyc("drain2", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);
        chk("full_pp_tail", 32'(res_o), 32'hC000);
        cyc("drain3", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);

        // Empty + push + pop
        cyc("empty_pp", 1'b1, 16'h3F80, 1'b0, 4'b0001, 1'b1, 1'b0);
        chk("empty_pp_count", 32'(count_o), 32'd1);
        chk("empty_pp_res",   32'(res_o),   32'h3F80);
        cyc("pop", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);
        cyc("pop_empty", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);

        // Classification
        do_reset("cls_rst");
        cyc("cls", 1'b1, 16'h7F80, 1'b0, 4'b0001, 1'b0, 1'b0);
        cyc("cls", 1'b1, 16'h7FC0, 1'b0, 4'b0001, 1'b0, 1'b0);
        cyc("cls", 1'b1, 16'h0001, 1'b0, 4'b0001, 1'b0, 1'b0);
        cyc("cls", 1'b1, 16'h8000, 1'b0, 4'b0001, 1'b0, 1'b0);
        cyc("cls", 1'b1, 16'h3F80, 1'b0, 4'b0001, 1'b0, 1'b0);
        chk("cls_nan_cnt", 32'(nan_cnt_o), 32'd1);
        chk("cls_c0", 32'(class_o), 32'b0100); cyc("cpop", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);
        chk("cls_c1", 32'(class_o), 32'b1000); cyc("cpop", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);
        chk("cls_c2", 32'(class_o), 32'b0010); cyc("cpop", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);
        chk("cls_c3", 32'(class_o), 32'b0001); cyc("cpop", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);
        chk("cls_c4", 32'(class_o), 32'b0000); cyc("cpop", 1'b0, 16'h0, 1'b0, 4'b0, 1'b1, 1'b0);

        // Counter saturation (dut2 has 2-bit counters)
        do_reset("sat_rst");
        for (int i = 0; i < 5; i++) cyc("sat", 1'b1, 16'h7F80, 1'b1, 4'b0100, 1'b0, 1'b0);
        chk("sat_ovf2", 32'(ovf_cnt2_o), 32'd3);
        chk("sat_ovf8", 32'(ovf_cnt_o),  32'd5);
        cyc("sat_clr", 1'b1, 16'h7F80, 1'b1, 4'b0100, 1'b0, 1'b1);
        chk("clr_wins2", 32'(ovf_cnt2_o), 32'd0);
        chk("clr_wins8", 32'(ovf_cnt_o),  32'd0);

        // Pointer wrap with continuous push+pop
        do_reset("wrap_rst");
        for (int i = 1; i <= 20; i++) begin
            cyc("wrap", 1'b1, 16'(i), 1'b0, 4'b1000, 1'b1, 1'b0);
            chk("wrap_res",   32'(res_o),   32'(i));
            chk("wrap_count", 32'(count_o), 32'd1);
            chk("wrap_drop",  32'(drop_o),  32'd0);
        end

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int n = 0; n < 3000; n++) begin
            pu_pct = ((n / 300) % 2 == 0) ? 75 : 35;
            pp_pct = ((n / 300) % 2 == 0) ? 35 : 75;
            r = 16'($urandom);
            k = $urandom_range(0, 3);
            if (k == 0) r[14:7] = 8'h00;
            else if (k == 1) r[14:7] = 8'hFF;
            if ($urandom_range(0, 3) == 0) r[6:0] = 7'h00;
            md = 4'b0001 << $urandom_range(0, 3);
            cyc("rand", ($urandom_range(0, 99) < pu_pct), r, 1'($urandom_range(0, 1)), md,
                ($urandom_range(0, 99) < pp_pct), ($urandom_range(0, 99) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
